// File: rtl/pos_move_sequencer_pkg.sv
// Shared types and constants for the position move sequencer.
// Holds the FSM state encoding, the PID saturation threshold and the 33-bit difference helper.
package pos_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_FAULT  = 2'd3
    } pos_seq_state_t;

    localparam logic signed [15:0] SAT_LIMIT = 16'sd3900;
    localparam int unsigned        EXT_W     = 33;

    // Magnitude of (a - b), computed one bit wider so full-range positions cannot overflow.
    function automatic logic [EXT_W-1:0] abs_diff33(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        logic signed [EXT_W-1:0] d;
        d = {a[31], a} - {b[31], b};
        if (d[EXT_W-1]) begin
            return {EXT_W{1'b0}} - d;
        end else begin
            return d;
        end
    endfunction

endpackage

// File: rtl/pos_move_sequencer_if.sv
// Move-command handshake bundle between the command registers and the sequencer.
interface pos_move_sequencer_if;
    logic               cmd_valid;
    logic               cmd_ready;
    logic signed [31:0] cmd_target;
    logic        [15:0] cmd_vmax;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_vmax,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_vmax,
        output cmd_ready
    );
endinterface

// File: rtl/pos_move_sequencer_tick_gen.sv
// Control-tick divider: one-cycle tick every DIVIDER clocks, asserted in the first cycle after reset.
// The PID core uses the identical counter so both stay phase-aligned.
module tick_gen #(
    parameter int DIVIDER = 5000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

    logic [CNT_W-1:0] r_div_cnt;
    logic             r_tick;

    // Divider counter; tick is registered as (next count == 0).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_tick    <= 1'b1;
        end else if (r_div_cnt == CNT_W'(DIVIDER - 1)) begin
            r_div_cnt <= {CNT_W{1'b0}};
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
            r_tick    <= 1'b0;
        end
    end

    assign tick = r_tick;
endmodule

// File: rtl/pos_move_sequencer.sv
// Move sequencer: ramps the PID setpoint toward a commanded target, confirms settling, faults on timeout.
// Optional build macro SAT_FAULT_EN adds a sustained-saturation fault on control_signal.
module pos_move_sequencer
    import pos_seq_pkg::*;
#(
    parameter int DIVIDER       = 5000,
    parameter int SETTLE_TOL    = 2,
    parameter int SETTLE_TICKS  = 200,
    parameter int TIMEOUT_TICKS = 40000,
    parameter int SAT_TICKS     = 2000
) (
    input  logic                 clk,
    input  logic                 reset,
    pos_move_sequencer_if.slave  cmd,
    input  logic                 abort,
    input  logic                 fault_clr,
    input  logic signed [31:0]   actual_pos,
    input  logic signed [15:0]   control_signal,
    output logic signed [31:0]   desired_pos,
    output logic                 pid_enable,
    output logic                 busy,
    output logic                 done,
    output logic                 fault,
    output logic [1:0]           state
);
    localparam int INPOS_W = $clog2(SETTLE_TICKS + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_TICKS + 1);

    pos_seq_state_t      r_state,   w_state_nxt;
    logic signed [31:0]  r_target,  w_target_nxt;
    logic        [15:0]  r_vmax,    w_vmax_nxt;
    logic signed [31:0]  r_desired, w_desired_nxt;
    logic                r_pid_en,  w_pid_en_nxt;
    logic                r_done,    w_done_nxt;
    logic                r_busy;
    logic                r_fault;
    logic [INPOS_W-1:0]  r_inpos_cnt, w_inpos_nxt, w_inpos_inc;
    logic [TMO_W-1:0]    r_settle_cnt, w_settle_nxt;

    logic                w_tick;
    logic                w_cmd_ready;
    logic                w_sat_trip;
    logic [EXT_W-1:0]    w_move_mag;
    logic [EXT_W-1:0]    w_settle_mag;
    logic                w_move_neg;
    logic                w_inpos;
    logic [31:0]         w_step;

    tick_gen #(.DIVIDER(DIVIDER)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_cmd_ready   = (r_state == ST_IDLE) && !abort;
    assign cmd.cmd_ready = w_cmd_ready;

    assign w_move_mag   = abs_diff33(r_target, r_desired);
    assign w_settle_mag = abs_diff33(r_target, actual_pos);
    assign w_move_neg   = (r_target < r_desired);
    assign w_inpos      = (w_settle_mag <= EXT_W'(SETTLE_TOL));
    assign w_step       = {16'd0, r_vmax};
    assign w_inpos_inc  = r_inpos_cnt + INPOS_W'(1);

`ifdef SAT_FAULT_EN
    localparam int SAT_W = $clog2(SAT_TICKS + 1);

    logic [SAT_W-1:0] r_sat_cnt, w_sat_cnt_nxt;
    logic             w_sat_hit;

    assign w_sat_hit = (control_signal >= SAT_LIMIT) || (control_signal <= -SAT_LIMIT);

    // Consecutive saturated-tick counter, live only while a move is in progress.
    always_comb begin
        w_sat_cnt_nxt = r_sat_cnt;
        w_sat_trip    = 1'b0;
        if ((r_state == ST_MOVE) || (r_state == ST_SETTLE)) begin
            if (w_tick && !abort) begin
                if (w_sat_hit) begin
                    w_sat_cnt_nxt = r_sat_cnt + SAT_W'(1);
                    w_sat_trip    = (w_sat_cnt_nxt == SAT_W'(SAT_TICKS));
                end else begin
                    w_sat_cnt_nxt = {SAT_W{1'b0}};
                end
            end else begin
                w_sat_cnt_nxt = r_sat_cnt;
            end
        end else begin
            w_sat_cnt_nxt = {SAT_W{1'b0}};
        end
    end

    // Saturation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_cnt <= {SAT_W{1'b0}};
        end else begin
            r_sat_cnt <= w_sat_cnt_nxt;
        end
    end
`else
    logic w_unused_cs;
    assign w_unused_cs = ^control_signal;
    assign w_sat_trip  = 1'b0;
`endif

    // Next-state, setpoint ramp and settle bookkeeping.
    always_comb begin
        w_state_nxt   = r_state;
        w_target_nxt  = r_target;
        w_vmax_nxt    = r_vmax;
        w_desired_nxt = r_desired;
        w_pid_en_nxt  = r_pid_en;
        w_done_nxt    = 1'b0;
        w_inpos_nxt   = r_inpos_cnt;
        w_settle_nxt  = r_settle_cnt;

        case (r_state)
            ST_IDLE: begin
                // With the loop disabled the setpoint shadows the encoder for a bumpless start.
                if (!r_pid_en) begin
                    w_desired_nxt = actual_pos;
                end else begin
                    w_desired_nxt = r_desired;
                end
                if (w_cmd_ready && cmd.cmd_valid) begin
                    w_target_nxt = cmd.cmd_target;
                    w_vmax_nxt   = (cmd.cmd_vmax == 16'd0) ? 16'd1 : cmd.cmd_vmax;
                    w_state_nxt  = ST_MOVE;
                    w_pid_en_nxt = 1'b1;
                    w_inpos_nxt  = {INPOS_W{1'b0}};
                    w_settle_nxt = {TMO_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_MOVE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (w_sat_trip) begin
                        w_state_nxt  = ST_FAULT;
                        w_pid_en_nxt = 1'b0;
                    end else if (w_move_mag <= {17'd0, r_vmax}) begin
                        w_desired_nxt = r_target;
                        w_state_nxt   = ST_SETTLE;
                    end else if (w_move_neg) begin
                        w_desired_nxt = r_desired - w_step;
                    end else begin
                        w_desired_nxt = r_desired + w_step;
                    end
                end else begin
                    w_state_nxt = ST_MOVE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    if (w_inpos) begin
                        w_inpos_nxt = w_inpos_inc;
                    end else begin
                        w_inpos_nxt = {INPOS_W{1'b0}};
                    end
                    w_settle_nxt = r_settle_cnt + TMO_W'(1);
                    // Completion outranks timeout when both land on the same tick.
                    if (w_inpos && (w_inpos_inc == INPOS_W'(SETTLE_TICKS))) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else if ((w_settle_nxt == TMO_W'(TIMEOUT_TICKS)) || w_sat_trip) begin
                        w_state_nxt  = ST_FAULT;
                        w_pid_en_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_FAULT: begin
                w_pid_en_nxt = 1'b0;
                if (fault_clr) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FAULT;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_pid_en_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_target     <= 32'sd0;
            r_vmax       <= 16'd1;
            r_desired    <= 32'sd0;
            r_pid_en     <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_inpos_cnt  <= {INPOS_W{1'b0}};
            r_settle_cnt <= {TMO_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_target     <= w_target_nxt;
            r_vmax       <= w_vmax_nxt;
            r_desired    <= w_desired_nxt;
            r_pid_en     <= w_pid_en_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt == ST_MOVE) || (w_state_nxt == ST_SETTLE);
            r_fault      <= (w_state_nxt == ST_FAULT);
            r_inpos_cnt  <= w_inpos_nxt;
            r_settle_cnt <= w_settle_nxt;
        end
    end

    assign desired_pos = r_desired;
    assign pid_enable  = r_pid_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign fault       = r_fault;
    assign state       = r_state;
endmodule

// File: doc/pos_move_sequencer.md
# pos_move_sequencer

Command sequencer in front of the 20 kHz PID position loop. It accepts move commands through a valid/ready handshake and ramps `desired_pos` toward the target at a bounded per-tick step. It then confirms settling against `actual_pos` and reports `done`, or enters `FAULT` on timeout. It owns the PID enable and sits between the AXI command registers and the PID core.

## Interface
- `DIVIDER`, 5000: clk cycles per control tick (100 MHz → 20 kHz); must equal the PID core's divider.
- `SETTLE_TOL`, 2: allowed |target − actual_pos| in counts for "in position".
- `SETTLE_TICKS`, 200: consecutive in-position ticks required for `done`.
- `TIMEOUT_TICKS`, 40000: maximum ticks spent in SETTLE before fault.
- `SAT_TICKS`, 2000: consecutive saturated ticks before fault (only with `SAT_FAULT_EN`).

Ports:
- `clk`  in  1: system clock, 100 MHz.
- `reset`  in  1: synchronous, active-high reset.
- `cmd_valid`  in  1: move command valid.
- `cmd_ready`  out  1: command accepted when high together with `cmd_valid`.
- `cmd_target`  in  32 signed: absolute target position in counts.
- `cmd_vmax`  in  16 unsigned: maximum step per tick in counts; 0 is treated as 1.
- `abort`  in  1: stop the move and return to IDLE.
- `fault_clr`  in  1: leave FAULT.
- `actual_pos`  in  32 signed: encoder position.
- `control_signal`  in  16 signed: PID output, used for saturation monitoring.
- `desired_pos`  out  32 signed: setpoint to the PID core, registered.
- `pid_enable`  out  1: enables the PID core; low holds it in reset.
- `busy`  out  1: high in MOVE or SETTLE.
- `done`  out  1: one-cycle pulse when settling completes.
- `fault`  out  1: high in FAULT.
- `state`  out  2: current state for status readback.

## Operation
- States are IDLE=0, MOVE=1, SETTLE=2, FAULT=3.
- `cmd_ready` is `(state==IDLE) && !abort`, driven combinationally.
- Handshake:
  - On `cmd_valid && cmd_ready`, latch `cmd_target` and `cmd_vmax`, go to MOVE, and set `pid_enable=1`.
  - A command may be accepted on any clk cycle, tick or not.
- IDLE with `pid_enable=0` (before the first move, or after FAULT): `desired_pos` follows `actual_pos` every cycle, for a bumpless start.
- IDLE with `pid_enable=1`: `desired_pos` holds its value.
- MOVE, on each tick:
  - `diff = target − desired_pos`, computed at 33 bits signed.
  - If `|diff| ≤ vmax`: `desired_pos = target`, go to SETTLE.
  - Otherwise: `desired_pos += sign(diff)·vmax`.
- SETTLE, on each tick:
  - If `|target − actual_pos| ≤ SETTLE_TOL` (33-bit compare), increment the in-position count; otherwise clear it to 0.
  - When the count reaches `SETTLE_TICKS`: pulse `done` and go to IDLE.
  - When settle ticks reach `TIMEOUT_TICKS`: go to FAULT.
- FAULT: `pid_enable=0` and `fault=1`. `fault_clr` moves to IDLE, after which `desired_pos` tracks `actual_pos`.
- `abort` in MOVE or SETTLE:
  - Go to IDLE on the next edge, freeze `desired_pos` at its current value, keep `pid_enable=1`, no `done` pulse.
  - `abort` has no effect in IDLE or FAULT.
- Simultaneous events:
  - `abort` and `cmd_valid` in the same cycle: abort wins, no command is accepted.
  - Settle completion and `abort` on the same tick: abort wins, no `done`.
  - Timeout and completion on the same tick: completion wins.
- Reset mid-move: all state returns to reset values on the next edge. Counters clear.

## Timing
- Reset values: `desired_pos=0`, `pid_enable=0`, `busy=0`, `done=0`, `fault=0`, `state=IDLE`. The tick counter is 0, so the first tick is the first cycle after `reset` falls.
- Tick: `tick = (div_cnt==0)`, with the counter wrapping at `DIVIDER−1`. This keeps it phase-aligned with the PID core when both are released from reset together.
- Accept → MOVE is visible 1 cycle after the handshake edge.
- `desired_pos` updates 1 cycle after a tick cycle.
- A move of D counts takes `ceil(D/vmax)` ticks in MOVE.
- `done` is high for exactly 1 cycle, coincident with `state` returning to IDLE.
- A new command can be accepted in the cycle after `done`.

## Configuration
- `SAT_FAULT_EN` defined:
  - In MOVE or SETTLE, count consecutive ticks with `|control_signal| ≥ SAT_LIMIT`; clear the count on any unsaturated tick.
  - Reaching `SAT_TICKS` enters FAULT.
- `SAT_FAULT_EN` undefined: `control_signal` is ignored, no counter is synthesized, and FAULT is reachable only by settle timeout.

## Structure
- Package `pos_seq_pkg`:
  - state enum `pos_seq_state_t`;
  - `SAT_LIMIT = 16'sd3900`, the anti-windup threshold of the PID core;
  - the 33-bit helper width constant.
- Sub-module `tick_gen`: a parameterized `DIVIDER` counter producing a one-cycle `tick` with a synchronous reset. The PID core shares the same design.
- FSM and ramp arithmetic stay in the top module.

## Test plan
All scenarios use `DIVIDER=4`.
- Reset, then `actual_pos=50` → `desired_pos` follows to 50, `state=0`, `cmd_ready=1`, all other outputs 0.
- Command target=100, vmax=30 from 0, `actual_pos` forced to follow → `desired_pos` goes 30, 60, 90, 100 on successive ticks. After 200 in-position ticks, one `done` pulse and `state=0`.
- `abort` at `desired_pos=60` during MOVE → IDLE next cycle, `desired_pos` stays 60, no `done`, `pid_enable=1`.
- `cmd_valid` and `abort` asserted in the same cycle while IDLE → no accept, state stays IDLE.
- `actual_pos` held 10 counts from target → FAULT after 40000 SETTLE ticks with `pid_enable=0`. `fault_clr` → IDLE with `desired_pos` tracking `actual_pos`.
- With `SAT_FAULT_EN`, `control_signal=4000` held for 2000 ticks in MOVE → FAULT. Without it → no fault.
